// File: rtl/eq_ctrl_pkg_amisha.sv
// eq_ctrl_pkg_amisha: state encoding and limits shared by the serial equality checker.
package eq_ctrl_pkg_amisha;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int WIDTH_MAX = 32;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN = ST_RUN,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/eq1_cell_amisha.sv
// eq1_cell_amisha: 1-bit equality cell (XNOR), shared across all bit positions.
module eq1_cell_amisha (
    input  logic i0,
    input  logic i1,
    output logic eq
);
    assign eq = ~(i0 ^ i1);
endmodule

// File: rtl/seq_eq_ctrl_amisha.sv
// seq_eq_ctrl_amisha: serial WIDTH-bit equality checker, one bit per clock, LSB first.
// Optional EARLY_EXIT_EN finishes at the first mismatching bit.
module seq_eq_ctrl_amisha
    import eq_ctrl_pkg_amisha::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_amisha,
    input  logic             rst_amisha,
    input  logic             start_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             eq_amisha
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             acc_q, acc_d, busy_q, busy_d, done_q, done_d, eq_q, eq_d;
    logic             bit_eq, acc_nx, finish;

    eq1_cell_amisha u_cell (
        .i0(a_sh_q[0]),
        .i1(b_sh_q[0]),
        .eq(bit_eq)
    );

    assign acc_nx = acc_q & bit_eq;
`ifdef EARLY_EXIT_EN
    assign finish = (idx_q == LAST) | ~bit_eq;
`else
    assign finish = idx_q == LAST;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        case (state_q)
            S_IDLE: if (start_amisha) begin
                a_sh_d  = a_amisha;
                b_sh_d  = b_amisha;
                idx_d   = '0;
                acc_d   = 1'b1;
                busy_d  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d  = acc_nx;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // idx holds on the final bit so it never wraps
                idx_d  = finish ? idx_q : idx_q + 1'b1;
                if (finish) begin
                    eq_d    = acc_nx;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (rst_amisha) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
        end
    end

    assign busy_amisha = busy_q;
    assign done_amisha = done_q;
    assign eq_amisha   = eq_q;
endmodule
